// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the digit-serial add/subtract unit.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_SUB = 1'b0;
   localparam logic MODE_ADD = 1'b1;

endpackage

// File: rtl/addsub_slice.sv
// Combinational DIGIT-bit add/subtract slice with carry/borrow chaining.
module addsub_slice
   import serial_addsub_pkg::*;
#(
   parameter int unsigned DIGIT = 2
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             mode,
   input  logic             cin,
   output logic [DIGIT-1:0] d,
   output logic             cout
);

   logic [DIGIT:0] t;

   // One extra bit holds the carry (add) or, on wrap below zero, the borrow (sub).
   always_comb begin
      if (mode == MODE_ADD) begin
         t = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
      end else begin
         t = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, cin};
      end
      d    = t[DIGIT-1:0];
      cout = t[DIGIT];
   end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract: DIGIT bits per cycle, LSB first, carry held in a flop.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGIT  = 2,
   parameter int unsigned SIGNED = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             negative,
   output logic [WIDTH:0]   magnitude
);

   localparam int unsigned N  = WIDTH / DIGIT;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   state_t                 state_q, state_d;
   logic                   accept;
   logic [WIDTH-1:0]       a_q, b_q, sh_q;
   logic                   carry_q, mode_q, sa_q, sb_q;
   logic [CW-1:0]          cnt_q;
   logic [DIGIT-1:0]       slice_d;
   logic                   slice_c;
   logic [WIDTH+DIGIT-1:0] sh_cat;

   logic                   done_q, cout_q, ovf_q, neg_q;
   logic [WIDTH-1:0]       result_q;
   logic [WIDTH:0]         mag_q;

   logic                   neg_c, ovf_c;
   logic [WIDTH:0]         mag_c, ext_c;

   addsub_slice #(
      .DIGIT (DIGIT)
   ) u_slice (
      .a    (a_q[DIGIT-1:0]),
      .b    (b_q[DIGIT-1:0]),
      .mode (mode_q),
      .cin  (carry_q),
      .d    (slice_d),
      .cout (slice_c)
   );

   // New digit enters at the MSB side so after N cycles the result is aligned.
   assign sh_cat = {slice_d, sh_q};

   // Next-state logic; start is ignored while busy, including the done cycle.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start && !done_q) begin
               state_d = RUN;
               accept  = 1'b1;
            end
         end
         RUN:     if (cnt_q == CW'(N - 1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Flags and exact magnitude from the finished shift register and final carry.
   always_comb begin
      neg_c = 1'b0;
      ovf_c = 1'b0;
      ext_c = '0;
      mag_c = '0;
      if (SIGNED != 0) begin
         // Bit WIDTH of the sign-extended operation: the true sign of the result.
         neg_c = sa_q ^ sb_q ^ carry_q;
         ovf_c = neg_c ^ sh_q[WIDTH-1];
         ext_c = {neg_c, sh_q};
         mag_c = neg_c ? (~ext_c + 1'b1) : ext_c;
      end else begin
         neg_c = (mode_q == MODE_SUB) && carry_q;
         if (mode_q == MODE_ADD) mag_c = {carry_q, sh_q};
         else if (neg_c)         mag_c = {1'b1, {WIDTH{1'b0}}} - {1'b0, sh_q};
         else                    mag_c = {1'b0, sh_q};
      end
   end

   // Datapath: operand capture, digit shifting, and output load in DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         sh_q     <= '0;
         carry_q  <= 1'b0;
         mode_q   <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         neg_q    <= 1'b0;
         mag_q    <= '0;
      end else begin
         done_q <= (state_q == DONE);
         if (accept) begin
            a_q     <= a;
            b_q     <= b;
            mode_q  <= mode;
            carry_q <= carry_in;
            sa_q    <= a[WIDTH-1];
            sb_q    <= b[WIDTH-1];
            sh_q    <= '0;
            cnt_q   <= '0;
         end else if (state_q == RUN) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            sh_q    <= sh_cat[WIDTH+DIGIT-1:DIGIT];
            carry_q <= slice_c;
            cnt_q   <= cnt_q + 1'b1;
         end
         if (state_q == DONE) begin
            result_q <= sh_q;
            cout_q   <= carry_q;
            ovf_q    <= ovf_c;
            neg_q    <= neg_c;
            mag_q    <= mag_c;
         end
      end
   end

   assign busy      = (state_q != IDLE) || done_q;
   assign done      = done_q;
   assign result    = result_q;
   assign carry_out = cout_q;
   assign overflow  = ovf_q;
   assign negative  = neg_q;
   assign magnitude = mag_q;

endmodule
